mips_16_run_ctrl: RTL and testbench

MIPS_16_RUN_CTRL -- requirements
Module: mips_16_run_ctrl

---
 rtl/mips_16_run_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mips_16_run_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_16_run_ctrl.sv
// Run controller for a small MIPS-style core: loads a program into the
// instruction memory from a host stream, then resets and runs the core
// until a cycle budget, a breakpoint, or a host halt stops it.
//
// state | meaning
// IDLE  | core held in reset, waiting for a command
// LOAD  | accepting program words from the host into instruction memory
// CRST  | two-cycle core reset before execution starts
// RUN   | core advancing, exit conditions checked every cycle
// HALT  | core frozen out of reset so its state can be inspected
module mips_16_run_ctrl #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_load,
    input  logic [PC_WIDTH-1:0]    load_last,
    input  logic                   wr_valid,
    input  logic [INSTR_WIDTH-1:0] wr_data,
    output logic                   wr_ready,
    input  logic                   cmd_run,
    input  logic [CNT_WIDTH-1:0]   run_cycles,
    input  logic                   cmd_halt,
    input  logic                   break_en,
    input  logic [PC_WIDTH-1:0]    break_pc,
    input  logic [PC_WIDTH-1:0]    core_pc,
    output logic                   core_rst,
    output logic                   core_run,
    output logic                   imem_we,
    output logic [PC_WIDTH-1:0]    imem_waddr,
    output logic [INSTR_WIDTH-1:0] imem_wdata,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             done_cause,
    output logic [CNT_WIDTH-1:0]   cycle_count
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CRST, S_RUN, S_HALT} state_t;

    localparam logic [PC_WIDTH-1:0]  PC_ONE  = PC_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    localparam logic [1:0] CAUSE_BUDGET = 2'b00;
    localparam logic [1:0] CAUSE_BREAK  = 2'b01;
    localparam logic [1:0] CAUSE_HALT   = 2'b10;
    localparam logic [1:0] CAUSE_LOAD   = 2'b11;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    ptr_q, ptr_d;
    logic [PC_WIDTH-1:0]    last_q, last_d;
    logic [CNT_WIDTH-1:0]   budget_q, budget_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   crst_q, crst_d;
    logic                   we_q, we_d;
    logic [PC_WIDTH-1:0]    waddr_q, waddr_d;
    logic [INSTR_WIDTH-1:0] wdata_q, wdata_d;
    logic                   done_q, done_d;
    logic [1:0]             cause_q, cause_d;
    logic                   hs;

    assign hs = wr_valid && (state_q == S_LOAD);

    // Next-state logic: command decode, load pointer, run counter and exit priority.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        last_d   = last_q;
        budget_d = budget_q;
        cnt_d    = cnt_q;
        crst_d   = crst_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        done_d   = 1'b0;
        cause_d  = cause_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (cmd_load) begin
                    state_d = S_LOAD;
                    last_d  = load_last;
                    ptr_d   = '0;
                end else if (cmd_run) begin
                    state_d  = S_CRST;
                    budget_d = run_cycles;
                    cnt_d    = '0;
                    crst_d   = 1'b0;
                end
            end
            S_LOAD: begin
                // A word offered in the same cycle as a halt is still accepted.
                if (hs) begin
                    we_d    = 1'b1;
                    waddr_d = ptr_q;
                    wdata_d = wr_data;
                    ptr_d   = ptr_q + PC_ONE;
                end
                if ((hs && (ptr_q == last_q)) || cmd_halt) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    cause_d = CAUSE_LOAD;
                end
            end
            S_CRST: begin
                if (crst_q) begin
                    state_d = S_RUN;
                end else begin
                    crst_d = 1'b1;
                end
            end
            S_RUN: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
                if (cmd_halt) begin
                    state_d = S_HALT;
                    done_d  = 1'b1;
                    cause_d = CAUSE_HALT;
                end else if (break_en && (core_pc == break_pc)) begin
                    state_d = S_HALT;
                    done_d  = 1'b1;
                    cause_d = CAUSE_BREAK;
                end else if ((budget_q != '0) && (cnt_q == budget_q - CNT_ONE)) begin
                    state_d = S_HALT;
                    done_d  = 1'b1;
                    cause_d = CAUSE_BUDGET;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset also drops any pending memory write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            last_q   <= '0;
            budget_q <= '0;
            cnt_q    <= '0;
            crst_q   <= 1'b0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            cause_q  <= 2'b00;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            last_q   <= last_d;
            budget_q <= budget_d;
            cnt_q    <= cnt_d;
            crst_q   <= crst_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            done_q   <= done_d;
            cause_q  <= cause_d;
        end
    end

    assign core_run    = (state_q == S_RUN);
    assign core_rst    = (state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_CRST);
    assign wr_ready    = (state_q == S_LOAD);
    assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    assign imem_we     = we_q;
    assign imem_waddr  = waddr_q;
    assign imem_wdata  = wdata_q;
    assign done        = done_q;
    assign done_cause  = cause_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_mips_16_run_ctrl.sv
// Bench for mips_16_run_ctrl: directed host sequences, a toy core that
// steps its PC while core_run is high, and a behavioural model compared
// against the DUT on every falling edge.
module tb_mips_16_run_ctrl;

    localparam int PW   = 4;
    localparam int IW   = 16;
    localparam int CW   = 4;
    localparam int DEPTH = 1 << PW;
    localparam int CMAX  = (1 << CW) - 1;

    localparam int P_IDLE = 0, P_LOAD = 1, P_CRST = 2, P_RUN = 3, P_HALT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_load;
    logic [PW-1:0] load_last;
    logic          wr_valid;
    logic [IW-1:0] wr_data;
    logic          wr_ready;
    logic          cmd_run;
    logic [CW-1:0] run_cycles;
    logic          cmd_halt;
    logic          break_en;
    logic [PW-1:0] break_pc;
    logic [PW-1:0] core_pc;
    logic          core_rst;
    logic          core_run;
    logic          imem_we;
    logic [PW-1:0] imem_waddr;
    logic [IW-1:0] imem_wdata;
    logic          busy;
    logic          done;
    logic [1:0]    done_cause;
    logic [CW-1:0] cycle_count;

    mips_16_run_ctrl #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .cmd_load(cmd_load), .load_last(load_last),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .cmd_run(cmd_run), .run_cycles(run_cycles), .cmd_halt(cmd_halt),
        .break_en(break_en), .break_pc(break_pc), .core_pc(core_pc),
        .core_rst(core_rst), .core_run(core_run), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .busy(busy),
        .done(done), .done_cause(done_cause), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // Toy core: PC held at 0 in reset, advances only while allowed to run.
    always @(posedge clk) begin
        if (core_rst) core_pc <= '0;
        else if (core_run) core_pc <= core_pc + 1'b1;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Behavioural model state.
    int m_phase, m_left, m_count, m_budget, m_last, m_next, m_cause;
    bit m_done, m_we, m_valid;
    int m_waddr, m_wdata;

    initial begin
        m_valid = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_phase = P_IDLE; m_count = 0; m_budget = 0; m_last = 0;
                m_next = 0; m_done = 0; m_cause = 0; m_we = 0; m_left = 0;
                m_valid = 1;
            end else if (m_valid) begin
                m_we = 0;
                m_done = 0;
                case (m_phase)
                    P_IDLE, P_HALT: begin
                        if (cmd_load) begin
                            m_phase = P_LOAD; m_last = int'(load_last); m_next = 0;
                        end else if (cmd_run) begin
                            m_phase = P_CRST; m_left = 2; m_count = 0;
                            m_budget = int'(run_cycles);
                        end
                    end
                    P_LOAD: begin
                        if (wr_valid) begin
                            m_we = 1; m_waddr = m_next; m_wdata = int'(wr_data);
                            if (m_next == m_last) begin
                                m_phase = P_IDLE; m_done = 1; m_cause = 3;
                            end
                            m_next = (m_next + 1) % DEPTH;
                        end
                        if (cmd_halt && m_phase == P_LOAD) begin
                            m_phase = P_IDLE; m_done = 1; m_cause = 3;
                        end
                    end
                    P_CRST: begin
                        m_left--;
                        if (m_left == 0) m_phase = P_RUN;
                    end
                    P_RUN: begin
                        m_count = (m_count < CMAX) ? m_count + 1 : CMAX;
                        if (cmd_halt) begin
                            m_phase = P_HALT; m_done = 1; m_cause = 2;
                        end else if (break_en && core_pc == break_pc) begin
                            m_phase = P_HALT; m_done = 1; m_cause = 1;
                        end else if (m_budget != 0 && m_count == m_budget) begin
                            m_phase = P_HALT; m_done = 1; m_cause = 0;
                        end
                    end
                    default: m_phase = P_IDLE;
                endcase
            end
        end
    end

    // Compare the DUT against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("core_run", core_run, m_phase == P_RUN);
                chk("core_rst", core_rst, m_phase == P_IDLE || m_phase == P_LOAD || m_phase == P_CRST);
                chk("wr_ready", wr_ready, m_phase == P_LOAD);
                chk("busy", busy, m_phase == P_LOAD || m_phase == P_CRST || m_phase == P_RUN);
                chk("done", done, m_done);
                chk("done_cause", done_cause, m_cause[1:0]);
                chk("cycle_count", cycle_count, m_count[CW-1:0]);
                chk("imem_we", imem_we, m_we);
                if (m_we) begin
                    chk("imem_waddr", imem_waddr, m_waddr[PW-1:0]);
                    chk("imem_wdata", imem_wdata, m_wdata[IW-1:0]);
                end
            end
        end
    end

    // Observed write log and run-cycle tally for the literal checks.
    logic [PW-1:0] log_addr[$];
    logic [IW-1:0] log_data[$];
    int run_hi = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (imem_we === 1'b1) begin
                log_addr.push_back(imem_waddr);
                log_data.push_back(imem_wdata);
            end
            if (core_run === 1'b1) run_hi++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "bench timeout");
    end

    task automatic send_word(input logic [IW-1:0] d, input int gap);
        wr_valid = 1'b1;
        wr_data  = d;
        @(negedge clk);
        wr_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_done(input int maxc, input string nm);
        bit got = 0;
        for (int i = 0; i < maxc; i++) begin
            if (done === 1'b1) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        chk(nm, got, 1);
    endtask

    task automatic pulse_run(input logic [CW-1:0] n);
        run_cycles = n;
        cmd_run = 1'b1;
        @(negedge clk);
        cmd_run = 1'b0;
    endtask

    logic [IW-1:0] words[4];
    int n0;

    initial begin
        words[0] = 16'h00A1; words[1] = 16'h00B2; words[2] = 16'h00C3; words[3] = 16'h00D4;
        rst = 1'b1; cmd_load = 1'b0; load_last = '0; wr_valid = 1'b0; wr_data = '0;
        cmd_run = 1'b0; run_cycles = '0; cmd_halt = 1'b0; break_en = 1'b0; break_pc = '0;
        repeat (3) @(negedge clk);
        chk("rst core_rst", core_rst, 1);
        chk("rst core_run", core_run, 0);
        chk("rst busy", busy, 0);
        chk("rst wr_ready", wr_ready, 0);
        chk("rst cycle_count", cycle_count, 0);
        chk("rst done_cause", done_cause, 0);
        rst = 1'b0;

        // Four-word load with gaps between valid cycles.
        load_last = 4'd3; cmd_load = 1'b1;
        @(negedge clk);
        cmd_load = 1'b0;
        send_word(words[0], 1);
        send_word(words[1], 2);
        send_word(words[2], 1);
        send_word(words[3], 0);
        wait_done(5, "load done");
        chk("load cause", done_cause, 2'b11);
        chk("load writes", log_addr.size(), 4);
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            chk("load addr", log_addr[i], i);
            chk("load data", log_data[i], words[i]);
        end
        @(negedge clk);
        chk("load idle busy", busy, 0);

        // Budget of 5.
        run_hi = 0;
        pulse_run(4'd5);
        wait_done(40, "budget done");
        chk("budget run_hi", run_hi, 5);
        chk("budget count", cycle_count, 5);
        chk("budget cause", done_cause, 2'b00);
        chk("budget core_rst", core_rst, 0);
        @(negedge clk);

        // Breakpoint at 6 with unlimited budget: PC 0..6 runs seven cycles.
        break_en = 1'b1; break_pc = 4'd6;
        pulse_run(4'd0);
        wait_done(40, "break6 done");
        chk("break6 cause", done_cause, 2'b01);
        chk("break6 count", cycle_count, 7);
        @(negedge clk);

        // Breakpoint at 0 stops after a single RUN cycle.
        break_pc = 4'd0;
        pulse_run(4'd0);
        wait_done(40, "break0 done");
        chk("break0 count", cycle_count, 1);
        chk("break0 cause", done_cause, 2'b01);
        @(negedge clk);

        // Halt and breakpoint in the same RUN cycle: halt wins.
        cmd_halt = 1'b1;
        pulse_run(4'd0);
        wait_done(40, "prio done");
        cmd_halt = 1'b0;
        chk("prio cause", done_cause, 2'b10);
        chk("prio count", cycle_count, 1);
        @(negedge clk);
        break_en = 1'b0;

        // Load and run together from HALT: load wins; then abort after two words.
        load_last = 4'd3; cmd_load = 1'b1; cmd_run = 1'b1;
        @(negedge clk);
        cmd_load = 1'b0; cmd_run = 1'b0;
        chk("both wr_ready", wr_ready, 1);
        chk("both core_run", core_run, 0);
        n0 = log_addr.size();
        send_word(16'h0E01, 1);
        send_word(16'h0E02, 0);
        cmd_halt = 1'b1;
        @(negedge clk);
        cmd_halt = 1'b0;
        chk("abort done", done, 1);
        chk("abort cause", done_cause, 2'b11);
        wr_valid = 1'b1;
        repeat (3) @(negedge clk);
        wr_valid = 1'b0;
        @(negedge clk);
        chk("abort writes", log_addr.size() - n0, 2);

        // Full-memory load; the pointer wrap after the last word is harmless.
        load_last = 4'd15; cmd_load = 1'b1;
        @(negedge clk);
        cmd_load = 1'b0;
        n0 = log_addr.size();
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1; wr_data = 16'h1000 + 16'(i);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        wait_done(5, "full done");
        repeat (3) @(negedge clk);
        chk("full writes", log_addr.size() - n0, 16);
        for (int i = 0; i < 16 && n0 + i < log_addr.size(); i++) begin
            chk("full addr", log_addr[n0 + i], i);
            chk("full data", log_data[n0 + i], 16'h1000 + 16'(i));
        end

        // Counter saturation with an unlimited budget.
        pulse_run(4'd0);
        repeat (22) @(negedge clk);
        cmd_halt = 1'b1;
        @(negedge clk);
        cmd_halt = 1'b0;
        wait_done(5, "sat done");
        chk("sat count", cycle_count, 15);
        chk("sat cause", done_cause, 2'b10);
        @(negedge clk);

        // Reset in the middle of a run.
        pulse_run(4'd0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstrun core_rst", core_rst, 1);
        chk("rstrun core_run", core_run, 0);
        chk("rstrun count", cycle_count, 0);
        chk("rstrun done", done, 0);

        // Reset coinciding with a load handshake drops the write.
        load_last = 4'd3; cmd_load = 1'b1;
        @(negedge clk);
        cmd_load = 1'b0;
        n0 = log_addr.size();
        wr_valid = 1'b1; wr_data = 16'hBEEF; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; wr_valid = 1'b0;
        chk("rstload we", imem_we, 0);
        chk("rstload wr_ready", wr_ready, 0);
        @(negedge clk);
        chk("rstload writes", log_addr.size() - n0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
